// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if
//   Bundles the count stream and the checker status outputs.
//   master: the side that produces count_in/in_valid/clr and observes status.
//   slave : the checker itself.
//   Signals:
//     count_in   [WIDTH]  count value from upstream counter
//     in_valid            count_in is meaningful this cycle
//     clr                 synchronous clear of err_cnt and wrap_cnt
//     locked              checker is in LOCKED
//     err_pulse           one-cycle pulse on a sequence break while locked
//     wrap_pulse          one-cycle pulse on a max->0 step while locked
//     err_cnt    [ERR_W]  saturating break count
//     wrap_cnt   [WRAP_W] wrap count, rolls over
interface count_seq_checker_if #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
);
  logic [WIDTH-1:0]  count_in;
  logic              in_valid;
  logic              clr;
  logic              locked;
  logic              err_pulse;
  logic              wrap_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output count_in, in_valid, clr,
    input  locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt
  );

  modport slave (
    input  count_in, in_valid, clr,
    output locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt
  );
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Monitors a free-running counter stream and checks that every valid
//   sample is the previous sample + 1 (mod 2^WIDTH). Acquires lock after
//   LOCK_CNT consecutive good increments, flags breaks and wraps while
//   locked, and keeps a saturating break count and a rolling wrap count.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  count_seq_checker_if.slave (count_in, in_valid, clr in;
//          locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt out)
//   All outputs come straight from registers.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  count_seq_checker_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // LOCK_CNT is limited to 1..15, so a 4-bit good counter always suffices.
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  logic [1:0]        state;
  logic [WIDTH-1:0]  prev;
  logic [3:0]        good;
  logic              err_pulse_q;
  logic              wrap_pulse_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [WRAP_W-1:0] wrap_cnt_q;

  logic [WIDTH-1:0]  prev_inc;
  logic [3:0]        good_inc;
  logic              match;
  logic              max_to_zero;
  logic              err_hit;
  logic              wrap_hit;

  // Break counter holds at all-ones instead of rolling over.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Increment is WIDTH bits wide so the carry out of max is dropped.
  assign prev_inc    = prev + WIDTH'(1);
  assign good_inc    = good + 4'd1;
  assign match       = (bus.count_in == prev_inc);
  assign max_to_zero = (prev == {WIDTH{1'b1}}) && (bus.count_in == '0);
  assign err_hit     = bus.in_valid && (state == ST_LOCKED) && !match;
  assign wrap_hit    = bus.in_valid && (state == ST_LOCKED) && match && max_to_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      prev         <= '0;
      good         <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_cnt_q    <= '0;
      wrap_cnt_q   <= '0;
    end else begin
      err_pulse_q  <= err_hit;
      wrap_pulse_q <= wrap_hit;

      // Gaps in in_valid freeze the sequence tracking entirely.
      if (bus.in_valid) begin
        prev <= bus.count_in;
        case (state)
          ST_IDLE: begin
            good  <= '0;
            state <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (match) begin
              good <= good_inc;
              if (good_inc == LOCK_TGT) state <= ST_LOCKED;
            end else begin
              good <= '0;
            end
          end
          ST_LOCKED: begin
            if (!match) begin
              good  <= '0;
              state <= ST_ACQUIRE;
            end
          end
          default: begin
            good  <= '0;
            state <= ST_IDLE;
          end
        endcase
      end

      // clr wins over a same-edge increment; the pulses are unaffected.
      if (bus.clr) begin
        err_cnt_q  <= '0;
        wrap_cnt_q <= '0;
      end else begin
        if (err_hit)  err_cnt_q  <= sat_inc(err_cnt_q);
        if (wrap_hit) wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
    end
  end

  assign bus.locked     = (state == ST_LOCKED);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
//   Drives two checker instances from one stimulus stream:
//     inst 0: WIDTH=4, LOCK_CNT=4, ERR_W=8, WRAP_W=16
//     inst 1: WIDTH=4, LOCK_CNT=1, ERR_W=2, WRAP_W=16
//   A run-length model predicts every output; a compare process checks
//   both instances on each falling edge, and directed sections add
//   literal expectations.
module tb_count_seq_checker;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       in_valid;
  logic       clr;

  int n_cmp;
  int n_fail;

  count_seq_checker_if #(.WIDTH(4), .ERR_W(8), .WRAP_W(16)) if0 ();
  count_seq_checker_if #(.WIDTH(4), .ERR_W(2), .WRAP_W(16)) if1 ();

  assign if0.count_in = count_in;
  assign if0.in_valid = in_valid;
  assign if0.clr      = clr;
  assign if1.count_in = count_in;
  assign if1.in_valid = in_valid;
  assign if1.clr      = clr;

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(8), .WRAP_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(1), .ERR_W(2), .WRAP_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: "run" = matching samples since the last break or first sample.
  // Locked exactly when run >= LOCK_CNT.
  int lock_n [2] = '{4, 1};
  int err_mx [2] = '{255, 3};
  bit m_have [2];
  int m_prev [2];
  int m_run  [2];
  int m_err  [2];
  int m_wrap [2];
  bit m_ep   [2];
  bit m_wp   [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_have[i] = 1'b0;
        m_prev[i] = 0;
        m_run[i]  = 0;
        m_err[i]  = 0;
        m_wrap[i] = 0;
        m_ep[i]   = 1'b0;
        m_wp[i]   = 1'b0;
      end else begin
        bit was_locked;
        was_locked = m_have[i] && (m_run[i] >= lock_n[i]);
        m_ep[i] = 1'b0;
        m_wp[i] = 1'b0;
        if (in_valid) begin
          if (!m_have[i]) begin
            m_have[i] = 1'b1;
            m_run[i]  = 0;
          end else if (int'(count_in) == (m_prev[i] + 1) % 16) begin
            if (was_locked && m_prev[i] == 15 && count_in == 4'd0) m_wp[i] = 1'b1;
            if (m_run[i] < 1000) m_run[i]++;
          end else begin
            if (was_locked) m_ep[i] = 1'b1;
            m_run[i] = 0;
          end
          m_prev[i] = int'(count_in);
        end
        if (clr) begin
          m_err[i]  = 0;
          m_wrap[i] = 0;
        end else begin
          if (m_ep[i] && m_err[i] < err_mx[i]) m_err[i]++;
          if (m_wp[i]) m_wrap[i] = (m_wrap[i] + 1) % 65536;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic lk, input logic ep, input logic wp,
                          input logic [31:0] ec, input logic [31:0] wc);
    chk($sformatf("inst%0d.locked", i), {31'd0, lk},
        {31'd0, (m_have[i] && m_run[i] >= lock_n[i])});
    chk($sformatf("inst%0d.err_pulse", i), {31'd0, ep}, {31'd0, m_ep[i]});
    chk($sformatf("inst%0d.wrap_pulse", i), {31'd0, wp}, {31'd0, m_wp[i]});
    chk($sformatf("inst%0d.err_cnt", i), ec, m_err[i]);
    chk($sformatf("inst%0d.wrap_cnt", i), wc, m_wrap[i]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, if0.locked, if0.err_pulse, if0.wrap_pulse,
             {24'd0, if0.err_cnt}, {16'd0, if0.wrap_cnt});
    cmp_inst(1, if1.locked, if1.err_pulse, if1.wrap_pulse,
             {30'd0, if1.err_cnt}, {16'd0, if1.wrap_cnt});
  end

  task automatic send(input logic v, input logic [3:0] c, input logic k);
    in_valid = v;
    count_in = c;
    clr      = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] g;
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    count_in = 4'd0;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked", {31'd0, if0.locked}, 32'd0);
    chk("reset_err_cnt", {24'd0, if0.err_cnt}, 32'd0);
    chk("reset_wrap_cnt", {16'd0, if0.wrap_cnt}, 32'd0);
    rst = 1'b0;

    // Lock acquisition
    for (int v = 0; v < 4; v++) send(1'b1, 4'(v), 1'b0);
    chk("lock_not_yet", {31'd0, if0.locked}, 32'd0);
    send(1'b1, 4'd4, 1'b0);
    chk("lock_after_4", {31'd0, if0.locked}, 32'd1);
    chk("lock_err_cnt", {24'd0, if0.err_cnt}, 32'd0);

    // Wrap
    for (int v = 5; v < 16; v++) send(1'b1, 4'(v), 1'b0);
    chk("wrap_pulse_before", {31'd0, if0.wrap_pulse}, 32'd0);
    send(1'b1, 4'd0, 1'b0);
    chk("wrap_pulse", {31'd0, if0.wrap_pulse}, 32'd1);
    chk("wrap_cnt_1", {16'd0, if0.wrap_cnt}, 32'd1);
    send(1'b1, 4'd1, 1'b0);
    chk("wrap_pulse_gone", {31'd0, if0.wrap_pulse}, 32'd0);
    chk("wrap_locked", {31'd0, if0.locked}, 32'd1);

    // Sequence break and relock
    for (int v = 2; v < 7; v++) send(1'b1, 4'(v), 1'b0);
    send(1'b1, 4'd8, 1'b0);
    chk("break_err_pulse", {31'd0, if0.err_pulse}, 32'd1);
    chk("break_err_cnt", {24'd0, if0.err_cnt}, 32'd1);
    chk("break_unlocked", {31'd0, if0.locked}, 32'd0);
    send(1'b1, 4'd9, 1'b0);
    chk("break_pulse_gone", {31'd0, if0.err_pulse}, 32'd0);
    send(1'b1, 4'd10, 1'b0);
    send(1'b1, 4'd11, 1'b0);
    chk("relock_not_yet", {31'd0, if0.locked}, 32'd0);
    send(1'b1, 4'd12, 1'b0);
    chk("relock_after_12", {31'd0, if0.locked}, 32'd1);

    // Valid gaps, then clr on a wrap edge
    for (int v = 13; v < 20; v++) send(1'b1, 4'(v), 1'b0);
    chk("gap_wrap_cnt_2", {16'd0, if0.wrap_cnt}, 32'd2);
    repeat (7) send(1'b0, 4'd9, 1'b0);
    chk("gap_locked", {31'd0, if0.locked}, 32'd1);
    send(1'b1, 4'd4, 1'b0);
    chk("gap_no_err", {31'd0, if0.err_pulse}, 32'd0);
    chk("gap_still_locked", {31'd0, if0.locked}, 32'd1);
    chk("gap_err_cnt", {24'd0, if0.err_cnt}, 32'd1);
    for (int v = 5; v < 16; v++) send(1'b1, 4'(v), 1'b0);
    send(1'b1, 4'd0, 1'b1);
    chk("clr_wrap_pulse", {31'd0, if0.wrap_pulse}, 32'd1);
    chk("clr_wrap_cnt", {16'd0, if0.wrap_cnt}, 32'd0);
    chk("clr_err_cnt", {24'd0, if0.err_cnt}, 32'd0);

    // Two breaks to reach err_cnt=2, relocked
    send(1'b1, 4'd5, 1'b0);
    for (int v = 6; v < 10; v++) send(1'b1, 4'(v), 1'b0);
    send(1'b1, 4'd11, 1'b0);
    for (int v = 12; v < 16; v++) send(1'b1, 4'(v), 1'b0);
    chk("pre_rst_err_cnt", {24'd0, if0.err_cnt}, 32'd2);
    chk("pre_rst_locked", {31'd0, if0.locked}, 32'd1);

    // Asynchronous reset between edges
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", {31'd0, if0.locked}, 32'd0);
    chk("arst_err_cnt", {24'd0, if0.err_cnt}, 32'd0);
    chk("arst_wrap_cnt", {16'd0, if0.wrap_cnt}, 32'd0);
    chk("arst_err_pulse", {31'd0, if0.err_pulse}, 32'd0);
    chk("arst_wrap_pulse", {31'd0, if0.wrap_pulse}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int v = 7; v < 11; v++) send(1'b1, 4'(v), 1'b0);
    chk("post_rst_not_locked", {31'd0, if0.locked}, 32'd0);
    send(1'b1, 4'd11, 1'b0);
    chk("post_rst_locked", {31'd0, if0.locked}, 32'd1);

    // Saturation on the ERR_W=2, LOCK_CNT=1 instance
    cur = 4'd11;
    for (int i = 0; i < 5; i++) begin
      cur = cur + 4'd1;
      send(1'b1, cur, 1'b0);
      chk($sformatf("sat_locked_%0d", i), {31'd0, if1.locked}, 32'd1);
      cur = cur + 4'd3;
      send(1'b1, cur, 1'b0);
      chk($sformatf("sat_err_pulse_%0d", i), {31'd0, if1.err_pulse}, 32'd1);
      chk($sformatf("sat_err_cnt_%0d", i), {30'd0, if1.err_cnt}, exp_sat[i]);
    end

    // Randomized traffic with occasional breaks, clears and resets
    g = cur;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(199) == 0) begin
        in_valid = 1'b0;
        clr      = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        logic v;
        v = ($urandom_range(3) != 0);
        if (v) g = ($urandom_range(11) == 0) ? 4'($urandom) : g + 4'd1;
        send(v, v ? g : 4'($urandom), ($urandom_range(59) == 0));
      end
    end

    in_valid = 1'b0;
    clr      = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
